pcie_cq_bram_writer: RTL and testbench

Downstream consumer of the CQ engine's TLP FIFO. It waits for the CQ engine's memory-write request (MEM_WR_REQ) and then drains the buffered {keep, addr, data} beats of one write TLP into a single-port BRAM write interface with byte enables. Once the FIFO is empty and the last write has been issued, it returns a one-cycle MEM_WR_ACK, which releases the CQ engine to accept the next TLP. Beats whose address falls outside the BRAM window are dropped and counted.

---
 rtl/pcie_cq_bram_writer.sv | 78 +++++++
 tb/tb_pcie_cq_bram_writer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pcie_cq_bram_writer.sv
// pcie_cq_bram_writer: drains one buffered CQ write TLP from a standard-mode FIFO into a byte-enabled BRAM port.
// Out-of-window beats are dropped and counted; MEM_WR_ACK pulses once the last write has been issued.
module pcie_cq_bram_writer #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_WIDTH = KEEP_WIDTH + ADDR_WIDTH + DATA_WIDTH,
    parameter int BRAM_AW    = 10
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  MEM_WR_REQ,
    output logic                  MEM_WR_ACK,
    output logic                  FIFO_RD_EN,
    input  logic [FIFO_WIDTH-1:0] FIFO_RD_DATA,
    input  logic                  FIFO_RD_EMPTY,
    input  logic [8:0]            FIFO_RD_COUNT,
    output logic                  BRAM_EN,
    output logic [KEEP_WIDTH-1:0] BRAM_WE,
    output logic [BRAM_AW-1:0]    BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_DIN,
    output logic                  BUSY,
    output logic [15:0]           ERR_CNT,
    output logic [15:0]           BEAT_CNT
);
    typedef enum logic [1:0] {IDLE, DRAIN, ACK} state_t;
    state_t state, state_nxt;
    logic                  rd_vld;
    logic [15:0]           tlp_cnt;
    logic [KEEP_WIDTH-1:0] rd_keep;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  in_win;
    logic                  unused_ok;
    assign {rd_keep, rd_addr, rd_data} = FIFO_RD_DATA;
    assign in_win     = rd_addr[ADDR_WIDTH-1:BRAM_AW+3] == '0;
    assign FIFO_RD_EN = (state == DRAIN) & ~FIFO_RD_EMPTY;
    assign MEM_WR_ACK = state == ACK;
    assign BUSY       = state != IDLE;
    assign unused_ok  = ^{FIFO_RD_COUNT, rd_addr[2:0]};
    // DRAIN only ends once the pipeline behind the FIFO is empty too
    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = MEM_WR_REQ ? DRAIN : IDLE;
        else if (state == DRAIN)
            state_nxt = (FIFO_RD_EMPTY & ~FIFO_RD_EN & ~rd_vld) ? ACK : DRAIN;
        else
            state_nxt = IDLE;
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            rd_vld    <= 1'b0;
            tlp_cnt   <= '0;
            BRAM_EN   <= 1'b0;
            BRAM_WE   <= '0;
            BRAM_ADDR <= '0;
            BRAM_DIN  <= '0;
            ERR_CNT   <= '0;
            BEAT_CNT  <= '0;
        end else begin
            state   <= state_nxt;
            rd_vld  <= FIFO_RD_EN;
            tlp_cnt <= (state == IDLE && MEM_WR_REQ) ? '0 : tlp_cnt + 16'(FIFO_RD_EN);
            BRAM_EN <= rd_vld & in_win & |rd_keep;
            BRAM_WE <= (rd_vld & in_win) ? rd_keep : '0;
            if (rd_vld) begin
                BRAM_ADDR <= rd_addr[BRAM_AW+2:3];
                BRAM_DIN  <= rd_data;
            end
            if (rd_vld & ~in_win & ~&ERR_CNT)
                ERR_CNT <= ERR_CNT + 16'd1;
            if (state == ACK)
                BEAT_CNT <= tlp_cnt;
        end
    end
endmodule

// File: tb/tb_pcie_cq_bram_writer.sv
// tb_pcie_cq_bram_writer: directed TLPs against a cycle-schedule model derived from the write latencies and window rules.
module tb_pcie_cq_bram_writer;
    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         MEM_WR_REQ = 1'b0;
    logic         MEM_WR_ACK, FIFO_RD_EN, FIFO_RD_EMPTY, BRAM_EN, BUSY;
    logic [103:0] FIFO_RD_DATA = '0;
    logic [8:0]   FIFO_RD_COUNT;
    logic [7:0]   BRAM_WE;
    logic [9:0]   BRAM_ADDR;
    logic [63:0]  BRAM_DIN;
    logic [15:0]  ERR_CNT, BEAT_CNT;

    pcie_cq_bram_writer dut (
        .CLK(CLK), .RST_N(RST_N), .MEM_WR_REQ(MEM_WR_REQ), .MEM_WR_ACK(MEM_WR_ACK),
        .FIFO_RD_EN(FIFO_RD_EN), .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_RD_EMPTY(FIFO_RD_EMPTY),
        .FIFO_RD_COUNT(FIFO_RD_COUNT), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR),
        .BRAM_DIN(BRAM_DIN), .BUSY(BUSY), .ERR_CNT(ERR_CNT), .BEAT_CNT(BEAT_CNT)
    );

    always #5 CLK = ~CLK;

    // standard-mode FIFO: dout valid the cycle after a read strobe; flushed by reset
    logic [103:0] mem [0:131071];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign FIFO_RD_EMPTY = (wr_ptr == rd_ptr);
    assign FIFO_RD_COUNT = 9'(wr_ptr - rd_ptr);
    always @(posedge CLK) begin
        if (!RST_N) rd_ptr <= wr_ptr;
        else if (FIFO_RD_EN) begin
            FIFO_RD_DATA <= mem[rd_ptr[16:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int   cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_q <= RST_N;
    end

    int checks = 0;
    int failures = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // model: expected events keyed by the cycle window in which they are visible
    bit           s_rd [int];
    bit           s_wr [int];
    bit           s_err[int];
    bit           s_ack[int];
    bit           s_busy[int];
    logic [7:0]   s_we [int];
    logic [9:0]   s_addr[int];
    logic [63:0]  s_din[int];
    int           s_beat[int];
    logic [103:0] tlp[$];

    task automatic push(input logic [7:0] k, input logic [31:0] a, input logic [63:0] d);
        mem[wr_ptr[16:0]] = {k, a, d};
        tlp.push_back({k, a, d});
        wr_ptr++;
    endtask

    // REQ seen in window t: pop i in t+1+i, BRAM write in t+3+i, ACK in t+n+3 (t+2 when empty)
    task automatic start(output int t);
        int n, ack;
        logic [103:0] b;
        t = cyc;
        n = tlp.size();
        for (int i = 0; i < n; i++) begin
            b = tlp[i];
            s_rd[t+1+i] = 1'b1;
            if (b[95:77] != 0) s_err[t+3+i] = 1'b1;
            else if (b[103:96] != 0) begin
                s_wr[t+3+i]   = 1'b1;
                s_we[t+3+i]   = b[103:96];
                s_addr[t+3+i] = b[76:67];
                s_din[t+3+i]  = b[63:0];
            end
        end
        ack = (n == 0) ? t + 2 : t + n + 3;
        s_ack[ack] = 1'b1;
        for (int c = t + 1; c <= ack; c++) s_busy[c] = 1'b1;
        s_beat[ack+1] = n;
        tlp.delete();
        MEM_WR_REQ = 1'b1;
    endtask

    task automatic finish(input int t, input int exp_lat, input int limit);
        bit seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge CLK);
            seen = MEM_WR_ACK;
        end
        MEM_WR_REQ = 1'b0;
        chk("ack_seen", 64'(seen), 64'd1);
        chk("ack_latency", 64'(cyc - t), 64'(exp_lat));
        repeat (2) @(negedge CLK);
    endtask

    logic [15:0] m_err = '0;
    int          m_beat = 0;
    int          n_wr = 0;
    logic [9:0]  last_addr;
    logic [7:0]  last_we;
    logic [63:0] last_din;
    always @(negedge CLK) begin
        if (!rst_q) begin
            m_err  = '0;
            m_beat = 0;
            chk("rst_outs", {MEM_WR_ACK, FIFO_RD_EN, BRAM_EN, BUSY, BRAM_WE, ERR_CNT, BEAT_CNT}, 64'd0);
            chk("rst_addr_din", {BRAM_ADDR, BRAM_DIN[53:0]}, 64'd0);
        end else begin
            if (s_err.exists(cyc)) m_err = (m_err == 16'hFFFF) ? m_err : m_err + 16'd1;
            if (s_beat.exists(cyc)) m_beat = s_beat[cyc];
            chk("rd_en", FIFO_RD_EN, s_rd.exists(cyc));
            chk("ack", MEM_WR_ACK, s_ack.exists(cyc));
            chk("busy", BUSY, s_busy.exists(cyc));
            chk("bram_en", BRAM_EN, s_wr.exists(cyc));
            chk("bram_we", BRAM_WE, s_wr.exists(cyc) ? s_we[cyc] : 8'h0);
            if (s_wr.exists(cyc)) begin
                chk("bram_addr", BRAM_ADDR, s_addr[cyc]);
                chk("bram_din", BRAM_DIN, s_din[cyc]);
            end
            chk("err_cnt", ERR_CNT, m_err);
            chk("beat_cnt", BEAT_CNT, 64'(m_beat));
            if (BRAM_EN) begin
                n_wr++;
                last_addr = BRAM_ADDR;
                last_we   = BRAM_WE;
                last_din  = BRAM_DIN;
            end
        end
    end

    initial begin
        int t, w0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        // single full beat
        w0 = n_wr;
        push(8'hFF, 32'h10, 64'h1122334455667788);
        start(t);
        finish(t, 4, 20);
        chk("t1_beat", BEAT_CNT, 64'd1);
        chk("t1_nwr", 64'(n_wr - w0), 64'd1);
        chk("t1_addr", last_addr, 64'd2);
        chk("t1_we", last_we, 64'hFF);
        chk("t1_din", last_din, 64'h1122334455667788);
        // four back-to-back beats
        w0 = n_wr;
        for (int i = 0; i < 4; i++) push(8'hFF, 32'h100 + 32'(8 * i), 64'hA5A5_0000_0000_0000 + 64'(i));
        start(t);
        finish(t, 7, 20);
        chk("t2_beat", BEAT_CNT, 64'd4);
        chk("t2_nwr", 64'(n_wr - w0), 64'd4);
        chk("t2_addr", last_addr, 64'h23);
        // partial and empty byte enables
        w0 = n_wr;
        push(8'h0F, 32'h200, 64'h0102030405060708);
        push(8'hF0, 32'h208, 64'h1112131415161718);
        push(8'h00, 32'h210, 64'h2122232425262728);
        start(t);
        finish(t, 6, 20);
        chk("t3_beat", BEAT_CNT, 64'd3);
        chk("t3_nwr", 64'(n_wr - w0), 64'd2);
        chk("t3_we", last_we, 64'hF0);
        // out-of-window drop, then saturation of the drop counter
        w0 = n_wr;
        push(8'hFF, 32'h2000, 64'hDEAD);
        start(t);
        finish(t, 4, 20);
        chk("t4_err", ERR_CNT, 64'd1);
        chk("t4_nwr", 64'(n_wr - w0), 64'd0);
        for (int i = 0; i < 65535; i++) push(8'hFF, 32'h2000, 64'(i));
        start(t);
        finish(t, 65538, 70000);
        chk("t4_err_sat", ERR_CNT, 64'hFFFF);
        chk("t4_beat", BEAT_CNT, 64'd65535);
        // empty FIFO request
        start(t);
        finish(t, 2, 20);
        chk("t5_beat", BEAT_CNT, 64'd0);
        repeat (4) @(negedge CLK);
        chk("t5_idle", {MEM_WR_ACK, BUSY}, 64'd0);
        // reset in the middle of a drain
        for (int i = 0; i < 8; i++) push(8'hFF, 32'h300 + 32'(8 * i), 64'(i));
        start(t);
        repeat (4) @(negedge CLK);
        RST_N = 1'b0;
        MEM_WR_REQ = 1'b0;
        for (int c = cyc + 1; c < cyc + 20; c++) begin
            s_rd.delete(c); s_wr.delete(c); s_err.delete(c); s_ack.delete(c);
            s_busy.delete(c); s_beat.delete(c);
        end
        @(negedge CLK);
        chk("t6_rst", {MEM_WR_ACK, FIFO_RD_EN, BUSY, BRAM_EN}, 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        push(8'hFF, 32'h40, 64'h5555);
        push(8'h3C, 32'h48, 64'h6666);
        start(t);
        finish(t, 5, 20);
        chk("t6_beat", BEAT_CNT, 64'd2);
        chk("t6_addr", last_addr, 64'd9);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
